// File: rtl/md_unit_pkg.sv
// Shared MD-unit definitions: MDop encoding,
// start-op kinds, FSM states and default latencies.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE = 3'd0,
    MD_MTHI = 3'd1,
    MD_MTLO = 3'd2,
    MD_MFHI = 3'd3,
    MD_MFLO = 3'd4
  } md_op_t;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_kind_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_arith.sv
// Combinational mult/multu/div/divu datapath.
// Ports: op, rs, rt in; res {hi,lo} and div_by_zero out.
import md_unit_pkg::*;

module md_arith (
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] res,
  output logic        div_by_zero
);

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] num;
  logic [31:0] den_raw;
  logic [31:0] den;
  logic [31:0] q;
  logic [31:0] r;
  logic [31:0] q_s;
  logic [31:0] r_s;

  // Signed divide works on magnitudes so that
  // 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    sgn         = (op == MD_DIV);
    a_neg       = sgn & rs[31];
    b_neg       = sgn & rt[31];
    num         = a_neg ? -rs : rs;
    den_raw     = b_neg ? -rt : rt;
    den         = (den_raw == 32'd0) ? 32'd1 : den_raw;
    q           = num / den;
    r           = num % den;
    q_s         = (a_neg ^ b_neg) ? -q : q;
    r_s         = a_neg ? -r : r;
    div_by_zero = op[1] & (rt == 32'd0);
    res         = '0;
    case (op)
      MD_MULT:
        res = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
      MD_MULTU:
        res = {32'd0, rs} * {32'd0, rt};
      default:
        res = {r_s, q_s};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit with HI/LO and busy.
// Ports: clk, reset(n), start, md_op, rs/rt_data, req; busy, hi, lo.
import md_unit_pkg::*;

module md_unit #(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   state;
  logic [3:0]  cnt;
  logic [63:0] pend;
  logic        pend_dz;
  logic [63:0] res;
  logic        dz;
  logic        running;
  logic        accept;
  logic        mt_ok;

  md_arith u_arith (
    .op          (md_op[1:0]),
    .rs          (rs_data),
    .rt          (rt_data),
    .res         (res),
    .div_by_zero (dz)
  );

  assign running = (state == MD_RUN);
  assign busy    = start | running;
  assign accept  = start & ~req & ~running;
  assign mt_ok   = ~start & ~req & ~running;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      pend    <= '0;
      pend_dz <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          if (accept) begin
            state   <= MD_RUN;
            cnt     <= md_op[1] ? 4'(DIV_CYCLES)
                                : 4'(MULT_CYCLES);
            pend    <= res;
            pend_dz <= dz;
          end else if (mt_ok && md_op == MD_MTHI) begin
            hi <= rs_data;
          end else if (mt_ok && md_op == MD_MTLO) begin
            lo <= rs_data;
          end
        end
        MD_RUN: begin
          if (cnt == 4'd1) begin
            state <= MD_IDLE;
            cnt   <= '0;
            if (!pend_dz) begin
              hi <= pend[63:32];
              lo <= pend[31:0];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: reference model
// plus directed vectors with literal expectations.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 0;
  logic        reset = 0;
  logic        start = 0;
  logic        req = 0;
  logic [2:0]  md_op = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int errs = 0;
  int checks = 0;

  md_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .req     (req),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void calc(
    input  logic [1:0]  k,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] r,
    output bit          z
  );
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint q;
    longint m;
    z = 0;
    r = '0;
    case (k)
      2'd0: r = sa * sb;
      2'd1: r = ua * ub;
      2'd2:
        if (b == 0) z = 1;
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      default:
        if (b == 0) z = 1;
        else begin
          q = ua / ub;
          m = ua % ub;
          r = {m[31:0], q[31:0]};
        end
    endcase
  endfunction

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  bit          m_zero;
  bit          m_run = 0;
  bit          m_valid = 0;
  int          m_edge = 0;
  int          m_done = 0;

  // Model: an op accepted at edge k commits at edge k+N.
  always @(posedge clk) begin
    m_edge++;
    if (!reset) begin
      m_hi = '0;
      m_lo = '0;
      m_run = 0;
      m_valid = 1;
    end else if (m_run) begin
      if (start || md_op == MD_MTHI || md_op == MD_MTLO) begin
        errs++;
        $display("FAIL hazard: MD op issued while running");
      end
      if (m_edge == m_done) begin
        m_run = 0;
        if (!m_zero) {m_hi, m_lo} = m_pend;
      end
    end else if (start && !req) begin
      m_run = 1;
      m_done = m_edge + (md_op[1] ? ND : NM);
      calc(md_op[1:0], rs_data, rt_data, m_pend, m_zero);
    end else if (!start && !req) begin
      if (md_op == MD_MTHI) m_hi = rs_data;
      if (md_op == MD_MTLO) m_lo = rs_data;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {63'd0, busy}, {63'd0, start | m_run});
      chk("hi", {32'd0, hi}, {32'd0, m_hi});
      chk("lo", {32'd0, lo}, {32'd0, m_lo});
    end
  end

  task automatic issue(input logic        s,
                       input logic [2:0]  op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic        r,
                       output int         n);
    bit done = 0;
    @(posedge clk);
    #2;
    start = s;
    md_op = op;
    rs_data = a;
    rt_data = b;
    req = r;
    n = 0;
    @(negedge clk);
    if (busy) n++;
    @(posedge clk);
    #2;
    start = 0;
    md_op = '0;
    req = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
      n++;
    end
    if (!done) chk("busy_timeout", 64'd1, 64'd0);
  endtask

  task automatic hl(input string nm,
                    input logic [31:0] eh,
                    input logic [31:0] el);
    chk({nm, "_hi"}, {32'd0, hi}, {32'd0, eh});
    chk({nm, "_lo"}, {32'd0, lo}, {32'd0, el});
  endtask

  initial begin
    int n;
    reset = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1;
    @(negedge clk);
    hl("reset", 32'h0, 32'h0);
    chk("reset_busy", {63'd0, busy}, 64'd0);

    issue(1, 3'(MD_MULT), 32'hFFFFFFFE, 32'd3, 0, n);
    chk("mult_cyc", 64'(n), 64'd6);
    hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

    issue(1, 3'(MD_DIV), 32'hFFFFFFF9, 32'd2, 0, n);
    chk("div_cyc", 64'(n), 64'd11);
    hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    issue(0, MD_MTHI, 32'h1234, 32'd0, 0, n);
    chk("mthi_cyc", 64'(n), 64'd0);
    issue(0, MD_MTLO, 32'h5678, 32'd0, 0, n);
    hl("mt", 32'h1234, 32'h5678);

    issue(1, 3'(MD_DIVU), 32'd55, 32'd0, 0, n);
    chk("divz_cyc", 64'(n), 64'd11);
    hl("divz", 32'h1234, 32'h5678);

    issue(1, 3'(MD_MULTU), 32'hFFFFFFFF,
          32'hFFFFFFFF, 1, n);
    chk("req_cyc", 64'(n), 64'd1);
    hl("req", 32'h1234, 32'h5678);

    issue(0, MD_MTLO, 32'hDEAD, 32'd0, 0, n);
    chk("mtlo_cyc", 64'(n), 64'd0);
    hl("mtlo", 32'h1234, 32'hDEAD);
    issue(0, MD_MTLO, 32'hBEEF, 32'd0, 1, n);
    hl("mtlo_req", 32'h1234, 32'hDEAD);

    issue(1, 3'(MD_MULTU), 32'hFFFFFFFF,
          32'hFFFFFFFF, 0, n);
    chk("multu_cyc", 64'(n), 64'd6);
    hl("multu", 32'hFFFFFFFE, 32'h00000001);

    issue(1, 3'(MD_DIV), 32'h80000000,
          32'hFFFFFFFF, 0, n);
    hl("div_ovf", 32'h0, 32'h80000000);

    issue(1, 3'(MD_DIVU), 32'd100, 32'd7, 0, n);
    hl("divu", 32'd2, 32'd14);

    issue(1, 3'(MD_DIV), 32'd7, 32'hFFFFFFFE, 0, n);
    hl("div_neg", 32'd1, 32'hFFFFFFFD);

    @(posedge clk);
    #2;
    start = 1;
    md_op = 3'(MD_DIV);
    rs_data = 32'd100;
    rt_data = 32'd3;
    @(posedge clk);
    #2;
    start = 0;
    md_op = '0;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    @(posedge clk);
    #2 reset = 1;
    @(negedge clk);
    hl("rst_mid", 32'h0, 32'h0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    repeat (15) @(negedge clk);
    hl("rst_late", 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
